// File: rtl/ldst_ahb_pkg.sv
// ldst_ahb_pkg: memop codes, AHB-Lite constants and memop decode helpers
package ldst_ahb_pkg;
  localparam logic [3:0] MO_NONE = 4'h0, MO_SB = 4'h1, MO_SH = 4'h2, MO_SW = 4'h3, MO_SD = 4'h4;
  localparam logic [3:0] MO_LB = 4'h9, MO_LBU = 4'hA, MO_LH = 4'hB, MO_LHU = 4'hC;
  localparam logic [3:0] MO_LW = 4'hD, MO_LWU = 4'hE, MO_LD = 4'hF;
  localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_B = 3'd0, HSIZE_H = 3'd1, HSIZE_W = 3'd2, HSIZE_D = 3'd3;

  function automatic logic [2:0] memop_size(input logic [3:0] op);
    return (op inside {MO_SW, MO_LW, MO_LWU}) ? HSIZE_W :
           (op inside {MO_SD, MO_LD})         ? HSIZE_D :
           (op inside {MO_SH, MO_LH, MO_LHU}) ? HSIZE_H : HSIZE_B;
  endfunction

  function automatic logic memop_is_store(input logic [3:0] op);
    return op inside {MO_SB, MO_SH, MO_SW, MO_SD};
  endfunction

  function automatic logic memop_is_signed(input logic [3:0] op);
    return op inside {MO_LB, MO_LH, MO_LW};
  endfunction

  function automatic logic memop_legal(input logic [3:0] op, input int data_w);
    return (op inside {MO_SB, MO_SH, MO_SW, MO_LB, MO_LBU, MO_LH, MO_LHU, MO_LW}) ||
           (data_w == 64 && (op inside {MO_SD, MO_LWU, MO_LD}));
  endfunction
endpackage

// File: rtl/ldst_lane_align.sv
// ldst_lane_align: store byte-lane alignment and load lane extraction with extension
module ldst_lane_align #(
  parameter int DATA_W = 32,
  localparam int OFS = $clog2(DATA_W / 8)
) (
  input  logic [OFS-1:0]    st_ofs,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] st_aligned,
  input  logic [OFS-1:0]    ld_ofs,
  input  logic [2:0]        ld_size,
  input  logic              ld_signed,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] ld_ext
);
  logic [DATA_W-1:0] sh, mask;
  logic sgn;
  // mask wraps to all-ones when the access is the full bus width
  always_comb begin
    st_aligned = st_data << {st_ofs, 3'b000};
    sh = ld_data >> {ld_ofs, 3'b000};
    mask = (DATA_W'(1) << (7'd8 << ld_size)) - DATA_W'(1);
    sgn = ld_signed & (|(sh & mask & ~(mask >> 1)));
    ld_ext = (sh & mask) | ({DATA_W{sgn}} & ~mask);
  end
endmodule

// File: rtl/ex2_ldst_ahb_t.sv
// ex2_ldst_ahb_t: pipelined AHB-Lite load/store master with overlapped
// address/data phases, wait states and two-cycle error response
module ex2_ldst_ahb_t
  import ldst_ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [3:0] HPROT_VAL = 4'h3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_memop,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_misaligned,
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [2:0]        HSIZE,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);
  localparam int OFS = $clog2(DATA_W / 8);

  logic aph_valid, aph_write, dph_valid, err_q, imm_valid, imm_mis;
  logic [ADDR_W-1:0] aph_addr;
  logic [3:0] aph_op, dph_op;
  logic [2:0] aph_size, req_size;
  logic [DATA_W-1:0] aph_wdata, dph_wdata, st_aligned, ld_ext;
  logic [OFS-1:0] dph_ofs;
  logic req_mis, req_bad, req_good, accept, adv, retire;

  ldst_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_ofs(req_addr[OFS-1:0]),
    .st_data(req_wdata),
    .st_aligned(st_aligned),
    .ld_ofs(dph_ofs),
    .ld_size(memop_size(dph_op)),
    .ld_signed(memop_is_signed(dph_op)),
    .ld_data(HRDATA),
    .ld_ext(ld_ext)
  );

  // bad requests bypass the bus, so they wait for an empty pipe to keep responses ordered
  always_comb begin
    req_size = memop_size(req_memop);
    req_mis = (req_memop != MO_NONE) & (|(req_addr[2:0] & 3'((4'd1 << req_size) - 4'd1)));
    req_bad = (req_memop != MO_NONE) & (req_mis | ~memop_legal(req_memop, DATA_W));
    req_good = (req_memop != MO_NONE) & ~req_bad;
    req_ready = ~RST & ~err_q & (~aph_valid | HREADY) & (~req_bad | (~aph_valid & ~dph_valid));
    accept = req_valid & req_ready;
    adv = aph_valid & HREADY & ~err_q;
    retire = dph_valid & HREADY;
    rsp_valid = ~RST & (imm_valid | retire);
    rsp_misaligned = rsp_valid & imm_valid & imm_mis;
    rsp_err = rsp_valid & (imm_valid ? ~imm_mis : (err_q | HRESP));
    rsp_rdata = (rsp_valid & ~imm_valid & ~err_q & ~HRESP & ~memop_is_store(dph_op)) ? ld_ext : '0;
    busy = aph_valid | dph_valid | err_q;
    HTRANS = (aph_valid & ~err_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  assign HADDR = aph_addr;
  assign HSIZE = aph_size;
  assign HWRITE = aph_write;
  assign HWDATA = dph_wdata;
  assign HBURST = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT = HPROT_VAL;

  always_ff @(posedge CLK) begin
    if (RST) begin
      aph_valid <= 1'b0;
      aph_write <= 1'b0;
      aph_addr <= '0;
      aph_op <= MO_NONE;
      aph_size <= '0;
      aph_wdata <= '0;
      dph_valid <= 1'b0;
      dph_op <= MO_NONE;
      dph_ofs <= '0;
      dph_wdata <= '0;
      err_q <= 1'b0;
      imm_valid <= 1'b0;
      imm_mis <= 1'b0;
    end else begin
      imm_valid <= accept & req_bad;
      imm_mis <= req_mis;
      if (accept & req_good) begin
        aph_addr <= req_addr;
        aph_op <= req_memop;
        aph_size <= req_size;
        aph_write <= memop_is_store(req_memop);
        aph_wdata <= memop_is_store(req_memop) ? st_aligned : '0;
      end
      aph_valid <= (accept & req_good) | (aph_valid & ~adv);
      if (adv) begin
        dph_op <= aph_op;
        dph_ofs <= aph_addr[OFS-1:0];
        dph_wdata <= aph_wdata;
      end
      dph_valid <= adv | (dph_valid & ~retire);
      err_q <= err_q ? ~HREADY : (dph_valid & HRESP & ~HREADY);
    end
  end

  hresp_first_cycle: assert property (@(posedge CLK) disable iff (RST)
    !(dph_valid && HREADY && HRESP && !err_q));
endmodule

// File: tb/tb_ex2_ldst_ahb_t.sv
// tb_ex2_ldst_ahb_t: random and directed traffic against a transaction-level
// reference model with a memory-backed AHB slave
module tb_ex2_ldst_ahb_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic req_valid, req_ready, rsp_valid, rsp_err, rsp_misaligned, busy;
  logic [3:0] req_memop, HPROT;
  logic [31:0] req_addr, req_wdata, rsp_rdata, HADDR, HWDATA, HRDATA;
  logic [2:0] HBURST, HSIZE;
  logic [1:0] HTRANS;
  logic HMASTLOCK, HWRITE, HREADY, HRESP;

  ex2_ldst_ahb_t #(.ADDR_W(32), .DATA_W(32), .HPROT_VAL(4'h3)) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_memop(req_memop),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_misaligned(rsp_misaligned), .busy(busy),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct { logic [3:0] op; logic [31:0] addr; logic [31:0] wdata; int waits; bit err; } req_t;
  typedef struct { logic [31:0] addr; bit write; logic [2:0] size; logic [31:0] wal; int waits; bit err; } bus_t;
  typedef struct { logic [31:0] rdata; bit err; bit mis; } rsp_t;

  req_t rq;
  bit rq_on, dph_on, err_ph, imm_pend;
  bus_t bus_q[$];
  rsp_t exp_q[$];
  bus_t cur;
  int wleft, n_chk, n_fail, n_acc, n_items;
  logic [7:0] refmem [1024];
  logic [7:0] slvmem [1024];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int sz(input logic [3:0] op);
    case (op)
      4'h2, 4'hB, 4'hC: return 1;
      4'h3, 4'hD, 4'hE: return 2;
      4'h4, 4'hF: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'h1, 4'h2, 4'h3, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
  endfunction

  function automatic bit misal(input logic [3:0] op, input logic [31:0] addr);
    return op != 4'h0 && (addr % (32'd1 << sz(op))) != 0;
  endfunction

  function automatic logic [31:0] ld_val(input logic [3:0] op, input logic [31:0] addr);
    int a = int'(addr[9:2]) * 4;
    logic [31:0] w = {refmem[a+3], refmem[a+2], refmem[a+1], refmem[a]} >> (8 * addr[1:0]);
    case (op)
      4'h9: return 32'($signed(w[7:0]));
      4'hA: return 32'(w[7:0]);
      4'hB: return 32'($signed(w[15:0]));
      4'hC: return 32'(w[15:0]);
      default: return w;
    endcase
  endfunction

  function automatic req_t rand_item();
    logic [3:0] ops [20] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'h1,
                             4'h3, 4'hD, 4'h9, 4'hB, 4'h4, 4'h5, 4'hE, 4'hF, 4'h3, 4'hD};
    req_t r;
    r.op = ops[$urandom_range(0, 19)];
    r.addr = 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 7) != 0) r.addr = r.addr & ~((32'd1 << sz(r.op)) - 32'd1);
    r.wdata = $urandom;
    r.waits = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 3));
    r.err = ($urandom_range(0, 9) == 0);
    return r;
  endfunction

  task automatic step();
    logic done, nonseq, bad, hr, hp;
    rsp_t e;
    bus_t b;
    int a;
    @(negedge clk);
    req_valid = rq_on;
    req_memop = rq.op;
    req_addr = rq.addr;
    req_wdata = rq.wdata;
    hr = 1'b1;
    hp = 1'b0;
    if (dph_on) begin
      if (wleft > 0) hr = 1'b0;
      else if (cur.err) begin hp = 1'b1; hr = err_ph; end
    end
    HREADY = hr;
    HRESP = hp;
    a = int'(cur.addr[9:2]) * 4;
    HRDATA = (dph_on && hr && !hp) ? {slvmem[a+3], slvmem[a+2], slvmem[a+1], slvmem[a]} : $urandom;
    #1;
    done = dph_on && hr;
    nonseq = bus_q.size() > 0 && !(dph_on && err_ph);
    if (rst) begin
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
    end else begin
      check("busy", 32'(busy), 32'(dph_on || bus_q.size() > 0));
      check("htrans", 32'(HTRANS), nonseq ? 32'd2 : 32'd0);
      if (nonseq) begin
        check("haddr", HADDR, bus_q[0].addr);
        check("hwrite", 32'(HWRITE), 32'(bus_q[0].write));
        check("hsize", 32'(HSIZE), 32'(bus_q[0].size));
      end
      check("rsp_valid", 32'(rsp_valid), 32'(imm_pend || done));
      if ((imm_pend || done) && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_misaligned", 32'(rsp_misaligned), 32'(e.mis));
      end
      if (done && cur.write && !cur.err) begin
        check("hwdata", HWDATA, cur.wal);
        for (int k = 0; k < (1 << cur.size); k++)
          slvmem[int'(cur.addr[9:0]) + k] = HWDATA[8 * (int'(cur.addr[1:0]) + k) +: 8];
      end
      if (rq_on) begin
        bad = rq.op != 4'h0 && (misal(rq.op, rq.addr) || !legal(rq.op));
        check("req_ready", 32'(req_ready), 32'(!(dph_on && err_ph) && (bus_q.size() == 0 || hr) &&
              (!bad || (bus_q.size() == 0 && !dph_on))));
      end
    end
    imm_pend = 1'b0;
    if (done) dph_on = 1'b0;
    else if (dph_on && !hr) begin
      if (wleft > 0) wleft--;
      else if (cur.err) err_ph = 1'b1;
    end
    if (!rst && nonseq && hr) begin
      cur = bus_q.pop_front();
      dph_on = 1'b1;
      err_ph = 1'b0;
      wleft = cur.waits;
    end
    if (!rst && rq_on && req_ready) begin
      n_acc++;
      rq_on = 1'b0;
      if (rq.op != 4'h0) begin
        if (misal(rq.op, rq.addr) || !legal(rq.op)) begin
          e.rdata = 32'd0;
          e.mis = misal(rq.op, rq.addr);
          e.err = !e.mis;
          exp_q.push_back(e);
          imm_pend = 1'b1;
        end else begin
          b.addr = rq.addr;
          b.write = rq.op inside {[4'h1 : 4'h4]};
          b.size = 3'(sz(rq.op));
          b.wal = rq.wdata << (8 * rq.addr[1:0]);
          b.waits = rq.waits;
          b.err = rq.err;
          bus_q.push_back(b);
          e.err = rq.err;
          e.mis = 1'b0;
          e.rdata = (b.write || rq.err) ? 32'd0 : ld_val(rq.op, rq.addr);
          exp_q.push_back(e);
          if (b.write && !rq.err)
            for (int k = 0; k < (1 << sz(rq.op)); k++)
              refmem[int'(rq.addr[9:0]) + k] = 8'(rq.wdata >> (8 * k));
        end
      end
    end
    if (rst) begin
      dph_on = 1'b0;
      err_ph = 1'b0;
      imm_pend = 1'b0;
      bus_q.delete();
      exp_q.delete();
      refmem = slvmem;
    end
  endtask

  task automatic run_item(input req_t r);
    int t = 0;
    rq = r;
    rq_on = 1'b1;
    n_items++;
    while (rq_on && t < 300) begin step(); t++; end
    rq_on = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() > 0 || bus_q.size() > 0 || dph_on || imm_pend) && t < 300) begin step(); t++; end
    check("drain_pending", 32'(exp_q.size() + bus_q.size()), 32'd0);
  endtask

  req_t dir [12];

  initial begin
    rq = '{4'h0, 32'd0, 32'd0, 0, 1'b0};
    cur = '{32'd0, 1'b0, 3'd0, 32'd0, 0, 1'b0};
    req_valid = 1'b0; req_memop = 4'h0; req_addr = 32'd0; req_wdata = 32'd0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
    for (int i = 0; i < 1024; i++) begin refmem[i] = 8'h00; slvmem[i] = 8'h00; end
    dir[0]  = '{4'h3, 32'h100, 32'hDEADBEEF, 0, 1'b0};
    dir[1]  = '{4'h1, 32'h103, 32'h000000A5, 0, 1'b0};
    dir[2]  = '{4'h3, 32'h100, 32'h00800000, 0, 1'b0};
    dir[3]  = '{4'h9, 32'h102, 32'h0, 0, 1'b0};
    dir[4]  = '{4'hA, 32'h102, 32'h0, 0, 1'b0};
    dir[5]  = '{4'hD, 32'h200, 32'h0, 2, 1'b0};
    dir[6]  = '{4'hD, 32'h204, 32'h0, 0, 1'b0};
    dir[7]  = '{4'hD, 32'h300, 32'h0, 0, 1'b1};
    dir[8]  = '{4'hD, 32'h304, 32'h0, 0, 1'b0};
    dir[9]  = '{4'hB, 32'h101, 32'h0, 0, 1'b0};
    dir[10] = '{4'hF, 32'h100, 32'h0, 0, 1'b0};
    dir[11] = '{4'h0, 32'h100, 32'h0, 0, 1'b0};
    rst = 1'b1;
    repeat (3) step();
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwrite", 32'(HWRITE), 32'd0);
    check("rst_hsize", 32'(HSIZE), 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_mis", 32'(rsp_misaligned), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("hburst", 32'(HBURST), 32'd0);
    check("hprot", 32'(HPROT), 32'h3);
    check("hmastlock", 32'(HMASTLOCK), 32'd0);
    rst = 1'b0;
    foreach (dir[i]) run_item(dir[i]);
    drain();
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) step();
      run_item(rand_item());
    end
    drain();
    run_item('{4'h3, 32'h40, 32'h12345678, 3, 1'b0});
    for (int t = 0; t < 20 && !dph_on; t++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_item('{4'h3, 32'h80, 32'hCAFEF00D, 0, 1'b0});
    run_item('{4'hD, 32'h80, 32'h0, 1, 1'b0});
    drain();
    check("accepts", 32'(n_acc), 32'(n_items));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ex2_ldst_ahb_t.md
Name: ex2_ldst_ahb_t

Overview:
- Parametrised, pipelined AHB-Lite load/store master for the EX2 stage. Successor to the combinational address-phase-only memory interface.
- Accepts one memory op per cycle via valid/ready. Registers the address phase, overlaps it with the previous data phase, and handles HREADY wait states and the two-cycle HRESP error.
- Aligns store data and extracts/sign-extends load data. Returns in-order responses to writeback.

Parameters:
ADDR_W, 32, HADDR/request address width
DATA_W, 32, bus data width; 32 or 64 only
HPROT_VAL, 4'h3, constant driven on HPROT

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted this cycle when req_valid&req_ready
req_memop  input  4  memop code (ldst_ahb_pkg)
req_addr  input  ADDR_W  effective address
req_wdata  input  DATA_W  store data, LSB-justified
rsp_valid  output  1  one-cycle response pulse, in request order
rsp_rdata  output  DATA_W  extended load data; 0 for stores
rsp_err  output  1  bus error (HRESP) or illegal memop
rsp_misaligned  output  1  address not aligned to access size; no bus transfer
busy  output  1  any transfer in address or data phase
HADDR  output  ADDR_W  address
HBURST  output  3  constant 3'h0 (SINGLE)
HMASTLOCK  output  1  constant 0
HPROT  output  4  constant HPROT_VAL
HSIZE  output  3  log2 bytes
HTRANS  output  2  IDLE=0 / NONSEQ=2
HWRITE  output  1  1=store
HWDATA  output  DATA_W  aligned store data, data phase
HRDATA  input  DATA_W  read data
HREADY  input  1  transfer ready
HRESP  input  1  1=ERROR

Behaviour:
- Reset (RST sampled high): aph/dph slots empty, err_q=0. Outputs: HTRANS=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_*=0, busy=0. req_ready=0 while RST is high.
- Memop codes: 0 NONE; 1 SB, 2 SH, 3 SW, 4 SD; 9 LB, A LBU, B LH, C LHU, D LW, E LWU, F LD.
- SD, LWU and LD are legal only when DATA_W=64. Other codes are illegal. Size: B=0, H=1, W=2, D=3.
- Two slots:
  - aph: registered address phase; drives HADDR/HSIZE/HWRITE, HTRANS=NONSEQ.
  - dph: data phase; drives HWDATA, samples HRDATA.
- req_ready = ~err_q & (~aph_valid | HREADY). A misaligned or illegal request additionally needs aph and dph both empty.
- Accept (legal, aligned, memop!=0): load into aph next cycle. Store data is shifted left by 8*addr[OFS-1:0], zero-filled, where OFS=log2(DATA_W/8).
- Accept memop 0: consumed; no transfer, no response.
- Accept misaligned or illegal: rsp_valid the next cycle with rsp_misaligned or rsp_err, rsp_rdata=0. Misaligned takes priority.
- Advance: aph_valid & HREADY & ~err_q moves aph to dph. Simultaneous accept refills aph in the same edge, giving back-to-back NONSEQ with no bubble.
- Completion: dph_valid & HREADY & ~HRESP.
  - rsp_valid is asserted combinationally in that cycle (zero added latency).
  - rsp_rdata = HRDATA shifted right by 8*offset, then sign- or zero-extended per memop.
- Wait states: HREADY=0 holds aph and dph unchanged. HADDR/HTRANS/HWDATA are stable.
- Error handling:
  - Cycle N: dph_valid & HRESP & ~HREADY sets err_q.
  - Cycle N+1: HTRANS is forced IDLE while err_q=1, so a pending aph is not sampled.
  - Cycle N+1: HREADY=1 & HRESP=1 retires dph with rsp_valid=1, rsp_err=1, rsp_rdata=0. err_q clears.
  - Cycle N+2: aph re-presented as NONSEQ; the transfer is not lost.
- HRESP with HREADY=1 in the first cycle is a protocol violation; assertion only, treated as error.
- busy = aph_valid | dph_valid | err_q.
- RST mid-transfer: slots dropped, no response issued. The slave is expected to be reset with the core.

Decomposition:
- Package ldst_ahb_pkg: memop code localparams, HTRANS/HSIZE/HBURST constants, functions memop_size, memop_is_store, memop_is_signed, memop_legal(DATA_W).
- Sub-module ldst_lane_align, combinational, parametrised by DATA_W:
  - store shift-left;
  - load shift-right plus extend.
- Top level: slots, err_q, handshake.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, HREADY=1:
  - cycle+1: HTRANS=2, HADDR=0x100, HWRITE=1, HSIZE=2;
  - cycle+2: HWDATA=0xDEADBEEF, rsp_valid=1, rsp_err=0.
- SB addr 0x103, wdata 0x000000A5: HWDATA=0xA5000000. LB addr 0x102 with HRDATA=0x00800000: rsp_rdata=0xFFFFFF80. LBU, same address and data: 0x00000080.
- LW 0x200 then LW 0x204 back-to-back, HREADY=0 for 2 cycles in the first data phase:
  - HADDR holds 0x204 throughout;
  - responses arrive in order, no bubble after HREADY rises.
- Error on LW 0x300 with LW 0x304 pending:
  - HRESP=1/HREADY=0, then HTRANS=0 with HREADY=1, giving rsp_err=1;
  - next cycle NONSEQ 0x304 re-issues and completes rsp_err=0.
- LH addr 0x101: no HTRANS activity, rsp_misaligned=1 one cycle later. With DATA_W=32, memop F: rsp_err=1.
- Assert RST while a transfer is in the data phase: next cycle HTRANS=0, busy=0, rsp_valid=0; a new SW after reset completes normally.
